fetch_stage: RTL

Instruction-fetch stage with IF/ID pipeline register. It drives the instruction-memory address from the PC register and registers the fetched word, its PC and PC+4. It presents the registered op_code to the main decoder and redirects the PC when a branch resolves taken. It also provides stall and flush, so the core can move from single-cycle to pipelined operation.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage with IF/ID pipeline register, stall,
//                flush and taken-branch redirect. Optional misaligned-target
//                trap enabled by defining FETCH_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic [6:0]  op_code,
    output logic        misalign_err
);

    localparam logic [1:0] c_BOOT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] c_HALT = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic        r_if_valid;
    logic        w_redirect;
    logic        w_misalign;
    logic        w_flush;
    logic        w_load_target;
    logic        w_advance;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;
    // A bubble carrying stale branch/zero must never steer the PC.
    assign w_redirect = branch & zero & r_if_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = (branch_target[1:0] != 2'b00);
    assign w_target   = branch_target;
`else
    assign w_misalign = 1'b0;
    assign w_target   = branch_target & 32'hFFFF_FFFC;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT: w_state_next = c_RUN;
            c_RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (w_redirect && w_misalign) begin
                    w_state_next = c_HALT;
                end
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            c_HALT: w_state_next = c_HALT;
`endif
            default: w_state_next = c_BOOT;
        endcase
    end

    // Output/control decode: redirect beats stall, stall beats advance
    always_comb begin
        w_flush       = 1'b0;
        w_load_target = 1'b0;
        w_advance     = 1'b0;
        if (r_state == c_RUN) begin
            if (w_redirect) begin
                w_flush       = 1'b1;
                w_load_target = ~w_misalign;
            end else if (!stall) begin
                w_advance = 1'b1;
            end
        end
    end

    // PC and IF/ID datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= RESET_PC;
            r_if_pc_plus4 <= RESET_PC + 32'd4;
            r_if_valid    <= 1'b0;
        end else if (w_flush) begin
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
            if (w_load_target) begin
                r_pc <= w_target;
            end
        end else if (w_advance) begin
            r_if_instr    <= imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_valid    <= 1'b1;
            r_pc          <= w_pc_plus4;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
        end else if (w_flush && w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_addr   = r_pc;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_valid    = r_if_valid;
    assign op_code     = r_if_instr[6:0];

endmodule

`default_nettype wire
